button_debounce_multi: RTL and testbench

//  N-channel debouncer and edge detector for board push-buttons and switches, run from the 100 MHz board clock.

---
 rtl/button_debounce_multi.sv | 143 ++++++++++++++
 tb/tb_button_debounce_multi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_multi.sv
// N-channel push-button debouncer with press/release edge pulses and long-press detection.
// A shared prescaler tick paces every channel's stability and hold counters.
module button_debounce_multi #(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10,
    parameter int HOLD_TICKS   = 500,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic            tick
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [DW-1:0]   DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0]   STAB_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [N_CH-1:0] IDLE_PAD  = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [DW-1:0]   div_cnt_r;
    logic [DW-1:0]   div_nxt_s;
    logic            tick_r;
    logic [N_CH-1:0] sync1_r;
    logic [N_CH-1:0] sync2_r;
    logic [N_CH-1:0] sample_s;
    logic [N_CH-1:0] level_r;
    logic [N_CH-1:0] press_r;
    logic [N_CH-1:0] release_r;
    logic [SW-1:0]   stab_cnt_r [N_CH];

    // Next prescaler count, wrapping after DIV_LAST.
    always_comb begin
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_cnt_r + DW'(1);
        end
    end

    // Prescaler; tick_r is registered from the next count so it is high exactly while div_cnt_r == DIV_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            tick_r    <= (div_nxt_s == DIV_LAST);
        end
    end

    // Two-flop synchronizer, reset to the idle pad level so release from reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= IDLE_PAD;
            sync2_r <= IDLE_PAD;
        end else begin
            sync1_r <= button_in;
            sync2_r <= sync1_r;
        end
    end

    // Polarity-normalised sample, 1 = pressed.
    always_comb begin
        sample_s = sync2_r ^ IDLE_PAD;
    end

    // Stability counters: one agreeing tick restarts the count, STABLE_TICKS differing ticks commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stab_cnt_r[i] <= '0;
            end
        end else begin
            press_r   <= '0;
            release_r <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (!tick_r) begin
                    stab_cnt_r[i] <= stab_cnt_r[i];
                end else if (sample_s[i] == level_r[i]) begin
                    stab_cnt_r[i] <= '0;
                end else if (stab_cnt_r[i] == STAB_LAST) begin
                    stab_cnt_r[i] <= '0;
                    level_r[i]    <= sample_s[i];
                    press_r[i]    <= sample_s[i];
                    release_r[i]  <= ~sample_s[i];
                end else begin
                    stab_cnt_r[i] <= stab_cnt_r[i] + SW'(1);
                end
            end
        end
    end

    generate
        if (HOLD_TICKS > 0) begin : g_hold
            localparam int HW = $clog2(HOLD_TICKS + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
            localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_TICKS - 1);

            logic [HW-1:0]   hold_cnt_r [N_CH];
            logic [N_CH-1:0] long_r;

            // Hold counters saturate at HOLD_MAX, so btn_long fires only once per press.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    long_r <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        hold_cnt_r[i] <= '0;
                    end
                end else begin
                    long_r <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        if (!level_r[i]) begin
                            hold_cnt_r[i] <= '0;
                        end else if (tick_r && (hold_cnt_r[i] != HOLD_MAX)) begin
                            hold_cnt_r[i] <= hold_cnt_r[i] + HW'(1);
                            long_r[i]     <= (hold_cnt_r[i] == HOLD_PRE);
                        end else begin
                            hold_cnt_r[i] <= hold_cnt_r[i];
                        end
                    end
                end
            end

            assign btn_long = long_r;
        end else begin : g_no_hold
            assign btn_long = '0;
        end
    endgenerate

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign tick        = tick_r;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi with a 4-clk tick, 3-tick debounce and 5-tick long press.
module tb_button_debounce_multi;
    localparam int N_CH         = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int HOLD_TICKS   = 5;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] button_in = 4'hF;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_long;
    logic       tick;

    button_debounce_multi #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
        .HOLD_TICKS(HOLD_TICKS), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button_in(button_in), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press [4];
    int n_rel [4];
    int n_long [4];
    int t_press [4];
    int t_long [4];
    int both_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (btn_press[i] === 1'b1) begin n_press[i]++; t_press[i] = cyc; end
            if (btn_release[i] === 1'b1) n_rel[i]++;
            if (btn_long[i] === 1'b1) begin n_long[i]++; t_long[i] = cyc; end
            if (btn_press[i] === 1'b1 && btn_release[i] === 1'b1) both_seen++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; t_press[i] = 0; t_long[i] = 0;
        end
    endtask

    // Edge index (cycles since reset release) at which a pad change driven after edge c commits.
    function automatic int commit_edge(input int c);
        return ((c + 6) / 4) * 4 + 4 * (STABLE_TICKS - 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int tgt;
        clear_stats();

        // Reset with all pads pressed.
        run(3);
        check_val("reset_outputs", {btn_level, btn_press, btn_release, btn_long, tick}, 17'd0);
        rst_n = 1'b1;
        cyc = 0;
        clear_stats();
        step();
        check_val("post_rst_clk1", {btn_level, btn_press, btn_release, btn_long, tick}, 17'd0);
        step();
        check_val("post_rst_clk2", {btn_level, btn_press, btn_release, btn_long, tick}, 17'd0);
        step();
        check_val("first_tick", {31'd0, tick}, 32'd1);
        button_in = 4'h0;
        step();
        check_val("tick_one_clk", {31'd0, tick}, 32'd0);
        run(19);
        check_val("rst_no_press", n_press[0] + n_press[1] + n_press[2] + n_press[3], 32'd0);
        check_val("rst_level", {28'd0, btn_level}, 32'd0);

        // Clean press and release on ch0.
        clear_stats();
        c0 = cyc;
        button_in = 4'b0001;
        run(16);
        check_val("ch0_press_cnt", n_press[0], 32'd1);
        check_val("ch0_press_time", t_press[0], commit_edge(c0));
        check_val("ch0_latency_ok", {31'd0, (t_press[0] - c0 >= 11) && (t_press[0] - c0 <= 15)}, 32'd1);
        check_val("ch0_level", {31'd0, btn_level[0]}, 32'd1);
        button_in = 4'b0000;
        run(20);
        check_val("ch0_release_cnt", n_rel[0], 32'd1);
        check_val("ch0_no_long", n_long[0], 32'd0);
        check_val("ch0_level_low", {31'd0, btn_level[0]}, 32'd0);

        // Bouncing ch1, then stable high.
        clear_stats();
        for (int k = 0; k < 40; k++) begin
            button_in = {2'b00, (((k / 3) % 2) == 1) ? 1'b1 : 1'b0, 1'b0};
            step();
        end
        check_val("ch1_bounce_quiet", n_press[1] + n_rel[1], 32'd0);
        button_in = 4'b0010;
        run(20);
        check_val("ch1_press_cnt", n_press[1], 32'd1);
        check_val("ch1_level", {31'd0, btn_level[1]}, 32'd1);
        button_in = 4'b0000;
        run(20);
        check_val("ch1_release_cnt", n_rel[1], 32'd1);

        // Long press on ch2.
        clear_stats();
        button_in = 4'b0100;
        run(60);
        check_val("ch2_press_cnt", n_press[2], 32'd1);
        check_val("ch2_long_cnt", n_long[2], 32'd1);
        check_val("ch2_long_delay", t_long[2] - t_press[2], 32'd20);
        button_in = 4'b0000;
        run(20);
        check_val("ch2_release_cnt", n_rel[2], 32'd1);
        check_val("ch2_long_once", n_long[2], 32'd1);

        // Short press on ch2: released right at the press pulse, only 3 ticks held.
        clear_stats();
        button_in = 4'b0100;
        for (int k = 0; k < 20 && n_press[2] == 0; k++) step();
        check_val("ch2b_press_seen", n_press[2], 32'd1);
        button_in = 4'b0000;
        run(30);
        check_val("ch2b_no_long", n_long[2], 32'd0);
        check_val("ch2b_release_cnt", n_rel[2], 32'd1);

        // Simultaneous ch0 and ch3.
        clear_stats();
        button_in = 4'b1001;
        run(16);
        check_val("sim_press0", n_press[0], 32'd1);
        check_val("sim_press3", n_press[3], 32'd1);
        check_val("sim_same_clk", t_press[0], t_press[3]);
        check_val("sim_quiet12", n_press[1] + n_press[2] + n_rel[1] + n_rel[2], 32'd0);

        // Reset while ch0 release debounce is two ticks in.
        c0 = cyc;
        button_in = 4'b1000;
        tgt = ((c0 + 6) / 4) * 4 + 5;
        while (cyc < tgt) step();
        check_val("pre_reset_no_commit", n_rel[0], 32'd0);
        clear_stats();
        rst_n = 1'b0;
        #1;
        check_val("reset_async_clear", {btn_level, btn_press, btn_release, btn_long, tick}, 17'd0);
        button_in = 4'b0000;
        run(2);
        rst_n = 1'b1;
        run(20);
        check_val("reset_no_release", n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3], 32'd0);
        check_val("reset_no_press", n_press[0] + n_press[1] + n_press[2] + n_press[3], 32'd0);
        check_val("reset_level_low", {28'd0, btn_level}, 32'd0);
        check_val("press_release_exclusive", both_seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
